// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage core: arbitrates memory waits, EX redirects
// and load-use hazards, and keeps the memory-wait timeout and performance counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned MEM_TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_redirect,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  id_ex_stall,
    output logic                  ex_mem_stall,
    output logic                  mem_wb_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  mem_timeout,
    output logic [CNT_WIDTH-1:0]  stall_cycles,
    output logic [CNT_WIDTH-1:0]  flush_count
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_cnt_nxt;
    logic                mem_stall;
    logic                load_use;
    logic                rs1_hit;
    logic                rs2_hit;
    logic                redirect_taken;

    assign mem_stall = mem_req & ~mem_ready;
    assign rs1_hit   = id_uses_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit   = id_uses_rs2 & (id_rs2 == ex_rd);
    // x0 is hardwired, so a load targeting it never creates a dependency
    assign load_use  = ex_mem_read & (ex_rd != '0) & (rs1_hit | rs2_hit);

    // Priority arbitration: memory wait freezes everything, redirect squashes wrong-path work
    always_comb begin
        pc_stall       = 1'b0;
        if_id_stall    = 1'b0;
        id_ex_stall    = 1'b0;
        ex_mem_stall   = 1'b0;
        mem_wb_stall   = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        redirect_taken = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_stall = 1'b1;
            end else if (ex_redirect) begin
                if_id_flush    = 1'b1;
                id_ex_flush    = 1'b1;
                redirect_taken = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    // The entry cycle of a wait counts as the first consecutive wait cycle
    always_comb begin
        wait_cnt_nxt = '0;
        if (mem_stall) begin
            if (state == RUN) begin
                wait_cnt_nxt = WAIT_W'(1);
            end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                wait_cnt_nxt = wait_cnt;
            end else begin
                wait_cnt_nxt = wait_cnt + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            case (state)
                RUN:      state <= mem_stall ? MEM_WAIT : RUN;
                MEM_WAIT: state <= mem_stall ? MEM_WAIT : RUN;
                default:  state <= RUN;
            endcase
            wait_cnt <= wait_cnt_nxt;
            if (mem_stall && (wait_cnt_nxt == WAIT_W'(MEM_TIMEOUT))) begin
                mem_timeout <= 1'b1;
            end
            if (pc_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            end
            if (redirect_taken && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a reference model pushes expected outputs
// into a scoreboard queue as each step is driven; they are popped and checked mid-cycle.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned RW = 5;
    localparam int unsigned CW = 4;
    localparam int unsigned MT = 4;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, mem_req, mem_ready;
    logic          pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
    logic          if_id_flush, id_ex_flush, mem_timeout;
    logic [CW-1:0] stall_cycles, flush_count;

    pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_WIDTH(CW), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
        .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // stl = {pc, if_id, id_ex, ex_mem, mem_wb}; fl = {if_id, id_ex}
    typedef struct packed {
        logic [4:0]    stl;
        logic [1:0]    fl;
        logic          to;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   m_sc  = 0;
    int   m_fc  = 0;
    int   m_run = 0;
    bit   m_to  = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit req, input bit rdy, input bit red,
                        input bit lr, input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                        input logic [RW-1:0] rs2, input bit u1, input bit u2);
        exp_t e;
        exp_t got;
        bit   ms, lu;
        @(negedge clk);
        rst = r; mem_req = req; mem_ready = rdy; ex_redirect = red; ex_mem_read = lr;
        ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ms = req && !rdy;
        lu = lr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        e.stl = 5'b00000;
        e.fl  = 2'b00;
        if (!r) begin
            if (ms)       e.stl = 5'b11111;
            else if (red) e.fl  = 2'b11;
            else if (lu) begin
                e.stl = 5'b11000;
                e.fl  = 2'b01;
            end
        end
        e.to = m_to;
        e.sc = CW'(m_sc);
        e.fc = CW'(m_fc);
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        chk("stalls", 8'({pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall}), 8'(got.stl));
        chk("flushes", 8'({if_id_flush, id_ex_flush}), 8'(got.fl));
        chk("mem_timeout", 8'(mem_timeout), 8'(got.to));
        chk("stall_cycles", 8'(stall_cycles), 8'(got.sc));
        chk("flush_count", 8'(flush_count), 8'(got.fc));
        // model state as it will be after the coming rising edge
        if (r) begin
            m_sc = 0; m_fc = 0; m_run = 0; m_to = 1'b0;
        end else begin
            if (e.stl[4] && m_sc < int'(CMAX)) m_sc++;
            if (!ms && red && m_fc < int'(CMAX)) m_fc++;
            m_run = ms ? ((m_run < int'(MT)) ? m_run + 1 : m_run) : 0;
            if (m_run == int'(MT)) m_to = 1'b1;
        end
    endtask

    task automatic idle(input bit r);
        step(r, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; mem_req = 0; mem_ready = 0; ex_redirect = 0; ex_mem_read = 0;
        ex_rd = '0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;

        // reset dominates an active memory stall and redirect
        step(1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step(1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(0);

        // load-use, then x0 destination, then rs2 not used
        idle(1);
        step(0, 0, 0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1);
        idle(0);
        step(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 1);
        step(0, 0, 0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 0);
        step(0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd1, 1, 0);

        // redirect wins over load-use
        step(0, 0, 0, 1, 1, 5'd5, 5'd0, 5'd5, 0, 1);
        idle(0);

        // memory wait masks redirect until ready
        idle(1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step(0, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(0);

        // sticky timeout after MT consecutive wait cycles
        idle(1);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(0);
        step(0, 0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0);
        idle(1);
        idle(0);

        // short waits interrupted by ready never reach the timeout
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < int'(MT) - 1; j++) step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
            step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        end

        // saturating counters
        idle(1);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 1, 0);
        idle(0);
        for (int i = 0; i < 18; i++) step(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(0);
        idle(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage core (IF, ID, EX, MEM, WB).
- Drives the five per-register stall enables `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall`, `mem_wb_stall`, plus the `if_id` and `id_ex` flush controls.
- Resolves three hazard sources: multi-cycle data-memory waits, EX-stage control redirects and load-use dependencies.
- Tracks memory-wait duration for a sticky timeout and keeps saturating performance counters.

Parameters:
- `REG_ADDR_W`, 5, register index width.
- `CNT_WIDTH`, 32, width of the performance counters.
- `MEM_TIMEOUT`, 256, consecutive memory-wait cycles that set `mem_timeout`. Must be ≥ 1.

Ports:
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  synchronous active-high reset.
- `id_rs1`  input  REG_ADDR_W  ID-stage source register 1.
- `id_rs2`  input  REG_ADDR_W  ID-stage source register 2.
- `id_uses_rs1`  input  1  ID instruction reads rs1.
- `id_uses_rs2`  input  1  ID instruction reads rs2.
- `ex_rd`  input  REG_ADDR_W  EX-stage destination register.
- `ex_mem_read`  input  1  EX instruction is a load.
- `ex_redirect`  input  1  EX resolved a taken branch/jump or mispredict; PC is being redirected.
- `mem_req`  input  1  MEM-stage instruction is accessing data memory this cycle.
- `mem_ready`  input  1  data memory completes the access this cycle.
- `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall`, `mem_wb_stall`  output  1 each  hold the corresponding register.
- `if_id_flush`  output  1  load a bubble into IF/ID.
- `id_ex_flush`  output  1  load a bubble into ID/EX.
- `mem_timeout`  output  1  sticky error flag.
- `stall_cycles`  output  CNT_WIDTH  cycles with `pc_stall` = 1.
- `flush_count`  output  CNT_WIDTH  number of redirect flushes.

Behaviour:
- **Output timing:** stall/flush outputs are combinational from current inputs and registered state, so they take effect in the same cycle. FSM state, wait counter, `mem_timeout` and perf counters are registered.
- **Reset:** while `rst` = 1, all stall and flush outputs are forced to 0 regardless of inputs. On the reset edge: state ← RUN, wait counter ← 0, `mem_timeout` ← 0, `stall_cycles` ← 0, `flush_count` ← 0. A reset asserted during MEM_WAIT aborts the wait immediately.
- **Condition definitions:**
  - `mem_stall` = `mem_req` & ~`mem_ready`.
  - `load_use` = `ex_mem_read` & (`ex_rd` ≠ 0) & ((`id_uses_rs1` & `id_rs1` == `ex_rd`) | (`id_uses_rs2` & `id_rs2` == `ex_rd`)).
- **Priority: `mem_stall` > `ex_redirect` > `load_use`.**
  - `mem_stall`: all five stalls = 1; both flushes = 0. Redirect and load-use are ignored this cycle. They re-present naturally because EX is frozen.
  - `ex_redirect` (no `mem_stall`): `if_id_flush` = 1, `id_ex_flush` = 1, all stalls = 0. Load-use is suppressed because the ID instruction is wrong-path.
  - `load_use` (neither above): `pc_stall` = 1, `if_id_stall` = 1, `id_ex_flush` = 1. `id_ex_stall`, `ex_mem_stall`, `mem_wb_stall` = 0; `if_id_flush` = 0. This inserts exactly one bubble, and the hazard clears next cycle as the load advances.
  - None: all outputs 0.
- **FSM (2 states):**
  - RUN → MEM_WAIT when `mem_stall`.
  - MEM_WAIT → RUN on the first cycle with `mem_ready` = 1 or `mem_req` = 0. That cycle is not stalled.
  - MEM_WAIT holds otherwise.
- **Wait counter:**
  - Cleared in RUN.
  - Increments every MEM_WAIT cycle with `mem_stall`, saturating at `MEM_TIMEOUT`.
  - `mem_timeout` ← 1 on the edge where the counter reaches `MEM_TIMEOUT`; it stays set until `rst`.
  - Timeout does not release the stall; the pipeline remains frozen until `mem_ready`.
- **Perf counters:**
  - `stall_cycles` += 1 on each edge where `pc_stall` = 1.
  - `flush_count` += 1 on each edge where the redirect branch is taken.
  - Both saturate at all-ones and never wrap.
- **`ex_rd` = 0:** never causes a load-use stall (x0 is hardwired).

Test Plan:
- **Reset:** `rst` = 1 for 2 cycles with `mem_req` = 1, `mem_ready` = 0, `ex_redirect` = 1 → all stall/flush outputs 0 throughout, counters 0, `mem_timeout` 0. Release `rst` → all five stalls = 1 in that cycle.
- **Load-use:** `ex_mem_read` = 1, `ex_rd` = 5, `id_rs2` = 5, `id_uses_rs2` = 1 for one cycle → `pc_stall` = `if_id_stall` = `id_ex_flush` = 1, others 0, `stall_cycles` = 1. Repeat with `ex_rd` = 0 → no stall. Repeat with `id_uses_rs2` = 0 → no stall.
- **Redirect beats load-use:** `ex_redirect` = 1 together with the load-use condition → `if_id_flush` = `id_ex_flush` = 1, all stalls 0, `flush_count` increments 0→1.
- **Memory wait:** `mem_req` = 1, `mem_ready` = 0 for 3 cycles, then `mem_ready` = 1; `ex_redirect` = 1 throughout → all five stalls = 1 for exactly 3 cycles with no flushes. On the ready cycle: stalls 0, redirect flush asserted, state RUN, `stall_cycles` = 3.
- **Timeout:** with `MEM_TIMEOUT` = 4, hold `mem_stall` for 6 cycles → `mem_timeout` rises after the 4th stalled edge and stays 1 after `mem_ready`. Stalls remain 1 all 6 cycles. Only `rst` clears `mem_timeout`.
- **Saturation:** with `CNT_WIDTH` = 4, apply 20 load-use cycles → `stall_cycles` = 15 and holds at 15.
